mem_access_initiator: RTL

Initiator side of the data-memory load/store port, sitting between a core's memory stage and the shared data memory (via the multicore arbiter). It accepts one load/store request at a time from the core and validates mask, address and alignment. It drives the memory's addr/wdata/mask/wr_en/rd_en strobes until the arbiter acknowledges, then returns a single-cycle response with the load data or an error flag.

---
 rtl/mem_access_pkg.sv | 24 ++
 rtl/mem_req_checker.sv | 43 ++++
 rtl/mem_access_initiator.sv | 98 +++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory load/store initiator: FSM states,
// funct3 access-size encodings and the captured request record.
package mem_access_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [2:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_checker.sv
// Combinational legality check for a load/store request (mask, direction, range, alignment).
// Alignment checking is compiled in only when MISALIGN_CHECK_EN is defined.
module mem_req_checker
    import mem_access_pkg::*;
#(
    parameter int unsigned MemWords = 1024
) (
    input  logic        we_i,
    input  logic [2:0]  mask_i,
    input  logic [31:0] addr_i,
    output logic        illegal_o
);

    logic mask_bad;
    logic dir_bad;
    logic range_bad;
    logic misaligned;

    always_comb begin
        mask_bad = 1'b1;
        unique case (mask_i)
            MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU: mask_bad = 1'b0;
            default:                                  mask_bad = 1'b1;
        endcase
    end

    // Unsigned variants only make sense for loads.
    assign dir_bad   = we_i && ((mask_i == MASK_BU) || (mask_i == MASK_HU));
    assign range_bad = {2'b00, addr_i[31:2]} >= MemWords;

`ifdef MISALIGN_CHECK_EN
    assign misaligned = (((mask_i == MASK_H) || (mask_i == MASK_HU)) && addr_i[0])
                      || ((mask_i == MASK_W) && (addr_i[1:0] != 2'b00));
`else
    // Memory ignores the low address bits, so they pass through unchecked.
    logic unused_low_addr;
    assign unused_low_addr = ^addr_i[1:0];
    assign misaligned      = 1'b0;
`endif

    assign illegal_o = mask_bad || dir_bad || range_bad || misaligned;

endmodule

// File: rtl/mem_access_initiator.sv
// Single-outstanding load/store initiator between a core memory stage and the shared data memory.
// Optional alignment checking via MISALIGN_CHECK_EN (see mem_req_checker).
module mem_access_initiator
    import mem_access_pkg::*;
#(
    parameter int unsigned MemWords = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_mask_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [2:0]  mem_mask_o,
    output logic        mem_wr_en_o,
    output logic        mem_rd_en_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    state_e      state_q, state_d;
    mem_req_t    req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        illegal;

    mem_req_checker #(
        .MemWords (MemWords)
    ) u_checker (
        .we_i      (req_we_i),
        .mask_i    (req_mask_i),
        .addr_i    (req_addr_i),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    req_d.we    = req_we_i;
                    req_d.mask  = req_mask_i;
                    req_d.addr  = req_addr_i;
                    req_d.wdata = req_wdata_i;
                    rdata_d     = '0;
                    err_d       = illegal;
                    state_d     = illegal ? StResp : StIssue;
                end
            end
            StIssue: begin
                if (mem_ack_i) begin
                    rdata_d = req_q.we ? '0 : mem_rdata_i;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Every output is a register or decoded from state, never from req_* or mem_ack.
    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StResp);
    assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
    assign resp_err_o   = resp_valid_o && err_q;

    assign mem_addr_o   = req_q.addr;
    assign mem_wdata_o  = req_q.wdata;
    assign mem_mask_o   = req_q.mask;
    assign mem_wr_en_o  = (state_q == StIssue) && req_q.we;
    assign mem_rd_en_o  = (state_q == StIssue) && !req_q.we;

endmodule
